// File: rtl/rv_pkg.sv
// Shared RV32 decode definitions used by the decode/operand stage.
//   - Major opcode encodings
//   - Immediate format selector
//   - Register-file sizing: REG_RANGE is the architectural register
//     count, REG_FIELD_RANGE is the width of an rs/rd instruction field.
package rv_pkg;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;

   localparam int REG_RANGE       = 32;
   localparam int REG_FIELD_RANGE = 5;

   typedef enum logic [2:0] {
      FMT_R,
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J
   } imm_fmt_e;

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator.
//   instr_hi  in   25    instruction bits [31:7] (opcode bits carry no immediate)
//   fmt       in   enum  immediate format selected by the decoder
//   imm       out  XLEN  sign-extended immediate; 0 for R format
module imm_gen
   import rv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:7]     instr_hi,
   input  imm_fmt_e        fmt,
   output logic [XLEN-1:0] imm
);

   logic [31:0]        ins;
   logic signed [31:0] imm32;

   // Re-base to full instruction numbering so the field slices read like the ISA manual.
   assign ins = {instr_hi, 7'b0};

   always_comb begin
      imm32 = '0;
      unique case (fmt)
         FMT_I:   imm32 = {{20{ins[31]}}, ins[31:20]};
         FMT_S:   imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         FMT_B:   imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         FMT_U:   imm32 = {ins[31:12], 12'b0};
         FMT_J:   imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   // Signed size cast sign-extends when XLEN is wider than 32.
   assign imm = XLEN'(imm32);

endmodule

// File: rtl/decode_operand_stage.sv
// ID stage: decodes a fetched instruction, reads operands (with WB bypass),
// stalls on load-use, and registers the result into the ID/EX slot.
//   clk, reset (async, active-low)
//   in_valid/in_ready/in_instr/in_pc      fetch handshake
//   rf_raddr1/2 (comb), rf_rdata1/2       register-file read port
//   wb_we/wb_rd/wb_data                   writeback port (bypass source)
//   ex_valid/ex_is_load/ex_rd             instruction in EX (load-use detect)
//   flush                                 squash slot and incoming instruction
//   out_*                                 ID/EX slot, out_valid/out_ready handshake
module decode_operand_stage
   import rv_pkg::*;
#(
   parameter  int XLEN = 32,
   parameter  int NREG = REG_RANGE,
   localparam int AW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic [AW-1:0]   rf_raddr1,
   output logic [AW-1:0]   rf_raddr2,
   input  logic [XLEN-1:0] rf_rdata1,
   input  logic [XLEN-1:0] rf_rdata2,
   input  logic            wb_we,
   input  logic [AW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            ex_valid,
   input  logic            ex_is_load,
   input  logic [AW-1:0]   ex_rd,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_rs1_val,
   output logic [XLEN-1:0] out_rs2_val,
   output logic [XLEN-1:0] out_imm,
   output logic [AW-1:0]   out_rs1,
   output logic [AW-1:0]   out_rs2,
   output logic [AW-1:0]   out_rd,
   output logic [6:0]      out_opcode,
   output logic [2:0]      out_funct3,
   output logic            out_funct7b5,
   output logic            out_rd_we,
   output logic            out_is_load,
   output logic            out_illegal
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_val;
      logic [XLEN-1:0] rs2_val;
      logic [XLEN-1:0] imm;
      logic [AW-1:0]   rs1;
      logic [AW-1:0]   rs2;
      logic [AW-1:0]   rd;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic            funct7b5;
      logic            rd_we;
      logic            is_load;
      logic            illegal;
   } slot_t;

   // Register index 0 reads as zero; a same-cycle writeback beats the array read.
   function automatic logic [XLEN-1:0] operand_sel(input logic [AW-1:0]   r,
                                                   input logic [XLEN-1:0] rdata,
                                                   input logic            we,
                                                   input logic [AW-1:0]   wrd,
                                                   input logic [XLEN-1:0] wdata);
      if (r == '0)                 return '0;
      else if (we && (wrd == r))   return wdata;
      else                         return rdata;
   endfunction

   logic [REG_FIELD_RANGE-1:0] rs1_f, rs2_f, rd_f;
   logic [AW-1:0]              rs1, rs2, rd;
   logic [6:0]                 opcode;
   imm_fmt_e                   fmt;
   logic                       legal, uses_rs1, uses_rs2, writes_rd, is_load;
   logic [XLEN-1:0]            imm_raw;
   logic                       hazard, accept;
   logic                       valid_q, valid_d;
   slot_t                      slot_q, slot_d;

   assign opcode = in_instr[6:0];
   assign rd_f   = in_instr[7 +: REG_FIELD_RANGE];
   assign rs1_f  = in_instr[15 +: REG_FIELD_RANGE];
   assign rs2_f  = in_instr[20 +: REG_FIELD_RANGE];
   assign rd     = rd_f[AW-1:0];
   assign rs1    = rs1_f[AW-1:0];
   assign rs2    = rs2_f[AW-1:0];

   assign rf_raddr1 = rs1;
   assign rf_raddr2 = rs2;

   always_comb begin
      fmt       = FMT_R;
      legal     = 1'b1;
      uses_rs1  = 1'b0;
      uses_rs2  = 1'b0;
      writes_rd = 1'b0;
      is_load   = 1'b0;
      unique case (opcode)
         OP:          begin fmt = FMT_R; uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; end
         OP_IMM,
         JALR:        begin fmt = FMT_I; uses_rs1 = 1'b1; writes_rd = 1'b1; end
         LOAD:        begin fmt = FMT_I; uses_rs1 = 1'b1; writes_rd = 1'b1; is_load = 1'b1; end
         STORE:       begin fmt = FMT_S; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         BRANCH:      begin fmt = FMT_B; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         LUI, AUIPC:  begin fmt = FMT_U; writes_rd = 1'b1; end
         JAL:         begin fmt = FMT_J; writes_rd = 1'b1; end
         // Unknown opcodes claim no source registers so they never cause a stall.
         default:     legal = 1'b0;
      endcase
   end

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr_hi (in_instr[31:7]),
      .fmt      (fmt),
      .imm      (imm_raw)
   );

   assign hazard = ex_valid && ex_is_load && (ex_rd != '0) &&
                   ((uses_rs1 && (ex_rd == rs1)) || (uses_rs2 && (ex_rd == rs2)));
   assign in_ready = (!valid_q || out_ready) && !hazard && !flush;
   assign accept   = in_valid && in_ready;

   always_comb begin
      valid_d = valid_q;
      slot_d  = slot_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d         = 1'b1;
         slot_d.pc       = in_pc;
         slot_d.rs1_val  = operand_sel(rs1, rf_rdata1, wb_we, wb_rd, wb_data);
         slot_d.rs2_val  = operand_sel(rs2, rf_rdata2, wb_we, wb_rd, wb_data);
         slot_d.imm      = legal ? imm_raw : '0;
         slot_d.rs1      = rs1;
         slot_d.rs2      = rs2;
         slot_d.rd       = rd;
         slot_d.opcode   = opcode;
         slot_d.funct3   = in_instr[14:12];
         slot_d.funct7b5 = in_instr[30];
         slot_d.rd_we    = legal && writes_rd && (rd != '0);
         slot_d.is_load  = is_load;
         slot_d.illegal  = !legal;
      end else begin
         if (valid_q && out_ready) valid_d = 1'b0;
         // Track writebacks landing while the slot waits so EX never sees a stale operand.
         if (wb_we && (wb_rd != '0) && (wb_rd == slot_q.rs1)) slot_d.rs1_val = wb_data;
         if (wb_we && (wb_rd != '0) && (wb_rd == slot_q.rs2)) slot_d.rs2_val = wb_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         slot_q  <= '0;
      end else begin
         valid_q <= valid_d;
         slot_q  <= slot_d;
      end
   end

   assign out_valid    = valid_q;
   assign out_pc       = slot_q.pc;
   assign out_rs1_val  = slot_q.rs1_val;
   assign out_rs2_val  = slot_q.rs2_val;
   assign out_imm      = slot_q.imm;
   assign out_rs1      = slot_q.rs1;
   assign out_rs2      = slot_q.rs2;
   assign out_rd       = slot_q.rd;
   assign out_opcode   = slot_q.opcode;
   assign out_funct3   = slot_q.funct3;
   assign out_funct7b5 = slot_q.funct7b5;
   assign out_rd_we    = slot_q.rd_we;
   assign out_is_load  = slot_q.is_load;
   assign out_illegal  = slot_q.illegal;

endmodule

// File: tb/tb_decode_operand_stage.sv
module tb_decode_operand_stage;

   localparam int XLEN = 32;
   localparam int AW   = 5;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic [AW-1:0]   rf_raddr1, rf_raddr2;
   logic [XLEN-1:0] rf_rdata1, rf_rdata2;
   logic            wb_we;
   logic [AW-1:0]   wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            ex_valid, ex_is_load;
   logic [AW-1:0]   ex_rd;
   logic            flush;
   logic            out_valid, out_ready;
   logic [XLEN-1:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
   logic [AW-1:0]   out_rs1, out_rs2, out_rd;
   logic [6:0]      out_opcode;
   logic [2:0]      out_funct3;
   logic            out_funct7b5, out_rd_we, out_is_load, out_illegal;

   logic [XLEN-1:0] rf [32];
   int passed = 0;
   int total  = 0;

   assign rf_rdata1 = rf[rf_raddr1];
   assign rf_rdata2 = rf[rf_raddr2];

   always #5 clk = ~clk;

   decode_operand_stage #(.XLEN(XLEN), .NREG(32)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7b5(out_funct7b5),
      .out_rd_we(out_rd_we), .out_is_load(out_is_load), .out_illegal(out_illegal)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'h10 * i;
      rf[3] = 32'd7;
      rf[5] = 32'h55;
      rf[9] = 32'h99;
      rf[2] = 32'h22;
      reset = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = '0;
      wb_we = 1'b0; wb_rd = '0; wb_data = '0;
      ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = '0;
      flush = 1'b0; out_ready = 1'b0;
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_imm", out_imm, 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      #5 reset = 1'b1;

      // Fill the slot and hold it, then reset asynchronously mid-cycle.
      in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100;
      tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_imm", out_imm, 32'd0);
      chk("async_rst_rd", 32'(out_rd), 32'd0);
      chk("async_rst_pc", out_pc, 32'd0);
      chk("async_rst_rd_we", 32'(out_rd_we), 32'd0);
      #1 reset = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("addi_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("addi_valid", 32'(out_valid), 32'd1);
      chk("addi_imm", out_imm, 32'd5);
      chk("addi_rd", 32'(out_rd), 32'd1);
      chk("addi_rd_we", 32'(out_rd_we), 32'd1);
      chk("addi_rs1_val", out_rs1_val, 32'd0);
      chk("addi_pc", out_pc, 32'h100);

      // WB bypass in the accept cycle: add x4,x3,x3 with x3 being written to 9.
      in_instr = 32'h00318233; in_pc = 32'h104;
      wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'd9;
      tick();
      wb_we = 1'b0;
      chk("byp_rs1_val", out_rs1_val, 32'd9);
      chk("byp_rs2_val", out_rs2_val, 32'd9);
      chk("byp_rd", 32'(out_rd), 32'd4);
      chk("byp_opcode", 32'(out_opcode), 32'h33);

      // Load-use on rs1: add x6,x5,x1 behind lw x5.
      in_instr = 32'h00128333; in_pc = 32'h108;
      ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5;
      #1;
      chk("lu_rs1_stall", 32'(in_ready), 32'd0);
      tick();
      chk("lu_slot_drained", 32'(out_valid), 32'd0);
      ex_valid = 1'b0;
      #1;
      chk("lu_release", 32'(in_ready), 32'd1);
      tick();
      chk("lu_accept_valid", 32'(out_valid), 32'd1);
      chk("lu_accept_rd", 32'(out_rd), 32'd6);
      chk("lu_rs1_val", out_rs1_val, 32'h55);
      chk("lu_rs2_val", out_rs2_val, 32'h10);

      // Load-use on rs2: add x6,x1,x5.
      in_instr = 32'h00508333;
      ex_valid = 1'b1;
      #1;
      chk("lu_rs2_stall", 32'(in_ready), 32'd0);

      // lui x5 uses no source registers.
      in_instr = 32'h123452B7;
      #1;
      chk("lui_no_stall", 32'(in_ready), 32'd1);
      tick();
      chk("lui_imm", out_imm, 32'h12345000);
      chk("lui_rd_we", 32'(out_rd_we), 32'd1);

      // ex_rd = x0 never stalls, even against rs1 = x0.
      in_instr = 32'h00100333; ex_rd = 5'd0;
      #1;
      chk("exrd0_no_stall", 32'(in_ready), 32'd1);
      tick();
      ex_valid = 1'b0; ex_is_load = 1'b0;
      chk("exrd0_rd", 32'(out_rd), 32'd6);

      // Held slot refresh: sub x8,x2,x9.
      in_instr = 32'h40910433;
      tick();
      chk("sub_rs2_val", out_rs2_val, 32'h99);
      chk("sub_f7b5", 32'(out_funct7b5), 32'd1);
      in_valid = 1'b0; out_ready = 1'b0;
      wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'h1234;
      tick();
      chk("refresh_valid", 32'(out_valid), 32'd1);
      chk("refresh_rs2_val", out_rs2_val, 32'h1234);
      wb_rd = 5'd0; wb_data = 32'hDEAD;
      tick();
      wb_we = 1'b0;
      chk("wb_x0_rs2_val", out_rs2_val, 32'h1234);
      chk("wb_x0_rs1_val", out_rs1_val, 32'h22);

      // Flush with both an incoming instruction and an occupied slot.
      in_valid = 1'b1; in_instr = 32'hFE000CE3; flush = 1'b1;
      #1;
      chk("flush_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("flush_valid", 32'(out_valid), 32'd0);
      flush = 1'b0; out_ready = 1'b1;
      tick();
      chk("beq_valid", 32'(out_valid), 32'd1);
      chk("beq_imm", out_imm, 32'hFFFFFFF8);
      chk("beq_rd_we", 32'(out_rd_we), 32'd0);

      // Unknown opcode is still presented, flagged illegal.
      in_instr = 32'hFFFFFFFF;
      tick();
      in_valid = 1'b0;
      chk("ill_valid", 32'(out_valid), 32'd1);
      chk("ill_flag", 32'(out_illegal), 32'd1);
      chk("ill_rd_we", 32'(out_rd_we), 32'd0);
      chk("ill_imm", out_imm, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
